// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC register with a direct-mapped BTB predictor and 2-bit counters.
// Execute-stage resolution trains the BTB and redirects fetch on a misprediction.
module fetch_pc_predictor #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      BTB_ENTRIES  = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PredNextPCF,
    output logic             PredTakenF,
    input  logic             ResolveE,
    input  logic [WIDTH-1:0] PCE,
    input  logic             TakenE,
    input  logic [WIDTH-1:0] TargetE,
    input  logic [WIDTH-1:0] PredNextPCE,
    output logic             RedirectE
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = WIDTH - IDX - 2;
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    logic [WIDTH-1:0] pc_q, pc_d;

    logic             valid_q  [BTB_ENTRIES];
    logic [TAGW-1:0]  tag_q    [BTB_ENTRIES];
    logic [WIDTH-1:0] target_q [BTB_ENTRIES];
    logic [1:0]       ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx, e_idx;
    logic [TAGW-1:0]  f_tag, e_tag;
    logic             f_hit, e_hit;
    logic [WIDTH-1:0] actual_next_e;
    logic [1:0]       ctr_upd;

    assign PCF   = pc_q;
    assign f_idx = pc_q[IDX+1:2];
    assign f_tag = pc_q[WIDTH-1:IDX+2];
    assign e_idx = PCE[IDX+1:2];
    assign e_tag = PCE[WIDTH-1:IDX+2];

    // Registered BTB arrays give read-old behaviour on a same-entry update.
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign PredTakenF  = f_hit && ctr_q[f_idx][1];
    assign PredNextPCF = PredTakenF ? target_q[f_idx] : pc_q + FOUR;

    assign e_hit         = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign actual_next_e = TakenE ? TargetE : PCE + FOUR;
    assign RedirectE     = ResolveE && (actual_next_e != PredNextPCE);

    always_comb begin
        ctr_upd = ctr_q[e_idx];
        if (TakenE) begin
            if (ctr_q[e_idx] != 2'b11) ctr_upd = ctr_q[e_idx] + 2'b01;
        end else begin
            if (ctr_q[e_idx] != 2'b00) ctr_upd = ctr_q[e_idx] - 2'b01;
        end
    end

    always_comb begin
        pc_d = PredNextPCF;
        if (RedirectE) begin
            pc_d = actual_next_e;
        end else if (StallF) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else begin
            pc_q <= pc_d;
            if (ResolveE) begin
                if (e_hit) begin
                    ctr_q[e_idx] <= ctr_upd;
                    if (TakenE) target_q[e_idx] <= TargetE;
                end else if (TakenE) begin
                    valid_q[e_idx]  <= 1'b1;
                    tag_q[e_idx]    <= e_tag;
                    target_q[e_idx] <= TargetE;
                    ctr_q[e_idx]    <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: sequential fetch, stall, BTB training,
// counter saturation, redirect priority, aliasing and mid-run reset.
module tb_fetch_pc_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic [31:0] PCF;
    logic [31:0] PredNextPCF;
    logic        PredTakenF;
    logic        ResolveE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic [31:0] PredNextPCE;
    logic        RedirectE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_predictor #(
        .WIDTH       (32),
        .BTB_ENTRIES (16),
        .RESET_VECTOR(32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .PCF        (PCF),
        .PredNextPCF(PredNextPCF),
        .PredTakenF (PredTakenF),
        .ResolveE   (ResolveE),
        .PCE        (PCE),
        .TakenE     (TakenE),
        .TargetE    (TargetE),
        .PredNextPCE(PredNextPCE),
        .RedirectE  (RedirectE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                           input logic [31:0] pred);
        ResolveE    = 1'b1;
        PCE         = pce;
        TakenE      = tk;
        TargetE     = tgt;
        PredNextPCE = pred;
        #1;
    endtask

    task automatic idle();
        ResolveE    = 1'b0;
        PCE         = 32'h0;
        TakenE      = 1'b0;
        TargetE     = 32'h0;
        PredNextPCE = 32'h0;
        #1;
    endtask

    // Steer fetch to pc via a not-taken resolve at pc-4 with a wrong prediction.
    task automatic steer(input logic [31:0] pc, input string tag);
        resolve(pc - 32'h4, 1'b0, 32'h0, 32'hFFFF_FFF0);
        chk({tag, "_redir"}, RedirectE, 1);
        tick();
        idle();
        chk({tag, "_pcf"}, PCF, pc);
    endtask

    initial begin
        rst = 1'b1;
        StallF = 1'b0;
        ResolveE = 1'b0;
        PCE = 32'h0;
        TakenE = 1'b0;
        TargetE = 32'h0;
        PredNextPCE = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset and sequential fetch
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_taken", PredTakenF, 0);
        chk("rst_pred", PredNextPCF, 32'h4);
        chk("rst_redir", RedirectE, 0);
        tick();
        chk("seq_4", PCF, 32'h4);
        tick();
        chk("seq_8", PCF, 32'h8);
        StallF = 1'b1;
        tick();
        chk("stall1", PCF, 32'h8);
        tick();
        chk("stall2", PCF, 32'h8);
        chk("stall_taken", PredTakenF, 0);
        StallF = 1'b0;
        tick();
        chk("seq_c", PCF, 32'hC);
        tick();
        chk("seq_10", PCF, 32'h10);

        // Cold taken branch; same-cycle lookup of 0x10 sees the old (empty) entry
        resolve(32'h10, 1'b1, 32'h40, 32'h14);
        chk("cold_redir", RedirectE, 1);
        chk("cold_readold", PredNextPCF, 32'h14);
        tick();
        idle();
        chk("cold_pcf", PCF, 32'h40);
        chk("cold_redir_off", RedirectE, 0);
        steer(32'h10, "to10");
        chk("hit_taken", PredTakenF, 1);
        chk("hit_pred", PredNextPCF, 32'h40);

        // Counter training while fetch is stalled at 0x10: 10->01->00->00
        StallF = 1'b1;
        resolve(32'h10, 1'b0, 32'h40, 32'h14);
        chk("nt_no_redir", RedirectE, 0);
        tick();
        chk("ctr01_taken", PredTakenF, 0);
        chk("ctr01_pred", PredNextPCF, 32'h14);
        tick();
        tick();
        chk("ctr00_taken", PredTakenF, 0);
        chk("ctr00_pred", PredNextPCF, 32'h14);
        chk("ctr_stall_pcf", PCF, 32'h10);
        // 00 must not wrap: one taken gives 01 (not taken), second gives 10
        resolve(32'h10, 1'b1, 32'h40, 32'h40);
        chk("t_correct_noredir", RedirectE, 0);
        tick();
        chk("sat_lo_taken", PredTakenF, 0);
        tick();
        chk("ctr10_taken", PredTakenF, 1);
        tick();
        tick();
        // At 11 (saturated) one not-taken gives 10, still taken
        resolve(32'h10, 1'b0, 32'h40, 32'h14);
        tick();
        chk("sat_hi_taken", PredTakenF, 1);
        chk("sat_hi_pred", PredNextPCF, 32'h40);
        idle();

        // Redirect beats stall (JALR mispredict)
        resolve(32'h20, 1'b1, 32'h100, 32'h24);
        chk("jalr_redir", RedirectE, 1);
        tick();
        idle();
        StallF = 1'b0;
        chk("jalr_pcf", PCF, 32'h100);
        chk("jalr_pred", PredNextPCF, 32'h104);

        // Aliasing: 0x50 shares index 4 with 0x10, different tag
        resolve(32'h50, 1'b1, 32'h80, 32'h54);
        chk("alias_redir", RedirectE, 1);
        tick();
        idle();
        chk("alias_pcf", PCF, 32'h80);
        steer(32'h10, "alias10");
        chk("alias10_taken", PredTakenF, 0);
        chk("alias10_pred", PredNextPCF, 32'h14);
        steer(32'h50, "alias50");
        chk("alias50_taken", PredTakenF, 1);
        chk("alias50_pred", PredNextPCF, 32'h80);
        tick();
        chk("follow_pred", PCF, 32'h80);

        // Retrain 0x10, then reset with an update pending at 0x30
        resolve(32'h10, 1'b1, 32'h40, 32'h14);
        tick();
        idle();
        chk("retrain_pcf", PCF, 32'h40);
        steer(32'h10, "retrain10");
        chk("retrain_taken", PredTakenF, 1);
        rst = 1'b1;
        resolve(32'h30, 1'b1, 32'h200, 32'h34);
        tick();
        rst = 1'b0;
        idle();
        chk("midrst_pcf", PCF, 32'h0);
        chk("midrst_pred", PredNextPCF, 32'h4);
        steer(32'h10, "post10");
        chk("post10_taken", PredTakenF, 0);
        chk("post10_pred", PredNextPCF, 32'h14);
        steer(32'h30, "post30");
        chk("post30_pred", PredNextPCF, 32'h34);
        steer(32'h20, "post20");
        chk("post20_pred", PredNextPCF, 32'h24);

        // Correct not-taken prediction on a miss: no redirect, no disturbance
        resolve(32'h20, 1'b0, 32'h300, 32'h24);
        chk("correct_noredir", RedirectE, 0);
        tick();
        idle();
        chk("correct_pcf", PCF, 32'h24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_predictor.md
# fetch_pc_predictor

Parametrised fetch-stage program counter for the pipelined RISC-V core, replacing the fixed single-cycle PC selector. It holds PCF, predicts the next fetch address through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and honours stall. When the execute stage resolves a control-flow instruction, the block updates the BTB and issues a redirect whenever the prediction was wrong. The redirect output flushes the F/D and D/E pipeline registers.

## Interface
- WIDTH, 32: address width.
- BTB_ENTRIES, 16: BTB depth; power of two, at least 2.
- RESET_VECTOR, 32'h0: PCF value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- StallF  in  1  holds PCF; asserted by the hazard unit.
- PCF  out  WIDTH  current fetch address.
- PredNextPCF  out  WIDTH  predicted address of the instruction after PCF; the pipeline carries it to execute.
- PredTakenF  out  1  BTB hit with a taken prediction for PCF.
- ResolveE  in  1  execute holds a valid control-flow instruction (branch, JAL or JALR).
- PCE  in  WIDTH  PC of the resolving instruction.
- TakenE  in  1  resolved direction; always 1 for JAL and JALR.
- TargetE  in  WIDTH  resolved target (PCE+imm, or the ALU result for JALR).
- PredNextPCE  in  WIDTH  PredNextPCF as carried with that instruction.
- RedirectE  out  1  misprediction; the pipeline flushes the F/D and D/E registers.

## Operation
- IDX = log2(BTB_ENTRIES).
- Index = PC[IDX+1:2].
- Tag = PC[WIDTH-1:IDX+2].
- Each entry holds valid, tag, target[WIDTH-1:0] and ctr[1:0].
- Lookup is combinational on PCF.
  - hit = valid && tag match.
  - PredTakenF = hit && ctr[1].
  - PredNextPCF = PredTakenF ? target : PCF+4.
- PC+4 wraps modulo 2^WIDTH; no overflow flag.
- ActualNextE = TakenE ? TargetE : PCE+4.
- RedirectE = ResolveE && (ActualNextE != PredNextPCE). It is combinational and asserted in the same cycle as ResolveE.
- Next-PC priority, highest first:
  - rst: RESET_VECTOR.
  - RedirectE: ActualNextE. Redirect overrides StallF.
  - StallF: PCF is held.
  - otherwise: PredNextPCF.
- BTB update happens on the clock edge where ResolveE=1, looking up PCE:
  - Hit: ctr saturates up if TakenE and down otherwise (11 stays 11, 00 stays 00). If TakenE, target is overwritten with TargetE.
  - Miss and TakenE: allocate the entry. valid=1, tag from PCE, target=TargetE, ctr=2'b10 (weakly taken). Any conflicting entry is replaced.
  - Miss and not taken: no change.
- StallF does not block BTB updates.
- If the update targets the same entry being read for PCF in the same cycle, the lookup sees the pre-update contents (read-old).
- Target bits [1:0] are stored and returned unmodified. Alignment is not this block's job.

## Timing
- Reset at the clock edge with rst=1:
  - PCF=RESET_VECTOR.
  - All valid bits and ctr cleared to 0.
  - Pending ResolveE is ignored in that cycle and no update occurs.
- In the cycle after reset, PredTakenF=0, PredNextPCF=RESET_VECTOR+4 and RedirectE follows its inputs. The pipeline keeps ResolveE low during reset.
- Reset mid-operation discards all BTB state and any in-flight redirect.
- Latency:
  - Prediction: 0 cycles, combinational from PCF.
  - Redirect: PCF equals ActualNextE one edge after RedirectE.
  - A BTB update becomes visible to lookups on the cycle after the edge that writes it.
- Simultaneous RedirectE and StallF: PCF loads ActualNextE.
- Correct prediction: RedirectE=0, no PCF disturbance, BTB still updated.

## Test plan
- Reset and sequential fetch: rst pulse, RESET_VECTOR=0x0. Expect PCF=0x0, then 0x4, 0x8, 0xC on successive edges with PredTakenF=0 throughout. StallF=1 for 2 cycles at 0x8 holds PCF=0x8.
- Cold taken branch: ResolveE=1, PCE=0x10, TakenE=1, TargetE=0x40, PredNextPCE=0x14. Expect RedirectE=1 and PCF=0x40 next edge. Later fetch of 0x10 gives PredTakenF=1 and PredNextPCF=0x40.
- Counter saturation: resolve 0x10 not-taken three times with correct PredNextPCE each time. ctr goes 10→01→00→00. Next fetch at 0x10 gives PredTakenF=0 and PredNextPCF=0x14.
- Redirect beats stall: StallF=1 with a JALR mispredict at PCE=0x20, TargetE=0x100, PredNextPCE=0x24. Expect PCF=0x100 next edge.
- Aliasing with BTB_ENTRIES=16: allocate 0x10→0x40, then a taken branch at 0x50 (same index, new tag)→0x80. Fetch of 0x10 is a miss (PredNextPCF=0x14); fetch of 0x50 predicts 0x80.
- Reset mid-run: after the entry at 0x10 is trained, assert rst for 1 cycle. PCF=RESET_VECTOR and fetch of 0x10 predicts 0x14.
